// File: rtl/fir_param.sv
// Parametrised pipelined direct-form FIR: delay line, registered products, then
// accumulate/shift/saturate into DOUT, with a valid shift register tracking VIN.
module fir_param #(
  parameter int N_TAPS = 8,
  parameter int DW     = 13,
  parameter int CW     = 13,
  parameter int SAT    = 1
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic signed [DW-1:0] DIN,
  input  logic                 VIN,
  input  logic                 COEF_WE,
  input  logic [3:0]           COEF_ADDR,
  input  logic signed [CW-1:0] COEF_DATA,
  output logic signed [DW-1:0] DOUT,
  output logic                 VOUT
);

  localparam int PW = DW + CW;
  localparam int AW = PW + $clog2(N_TAPS);

  localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [AW-1:0] AMAX = AW'(DMAX);
  localparam logic signed [AW-1:0] AMIN = AW'(DMIN);

  logic signed [DW-1:0] x_q [N_TAPS];
  logic signed [CW-1:0] h_q [N_TAPS];
  logic signed [PW-1:0] p_q [N_TAPS];
  logic [1:0]           vld_q;
  logic signed [DW-1:0] dout_q;
  logic                 vout_q;

  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] r_d;
  logic signed [DW-1:0] dout_d;

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      acc_d = acc_d + AW'(p_q[i]);
    end
    // Arithmetic shift drops the Q1.(CW-1) fraction, rounding toward -inf.
    r_d    = acc_d >>> (CW - 1);
    dout_d = r_d[DW-1:0];
    if (SAT != 0) begin
      if (r_d > AMAX) begin
        dout_d = DMAX;
      end else if (r_d < AMIN) begin
        dout_d = DMIN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
        p_q[i] <= '0;
      end
      vld_q  <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
    end else begin
      if (VIN) begin
        x_q[0] <= DIN;
        for (int i = 1; i < N_TAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
      end
      // Out-of-range addresses match no tap and fall through untouched.
      for (int i = 0; i < N_TAPS; i++) begin
        if (COEF_WE && (int'(COEF_ADDR) == i)) begin
          h_q[i] <= COEF_DATA;
        end
      end
      if (vld_q[0]) begin
        for (int i = 0; i < N_TAPS; i++) begin
          p_q[i] <= PW'(x_q[i]) * PW'(h_q[i]);
        end
      end
      vld_q  <= {vld_q[0], VIN};
      vout_q <= vld_q[1];
      if (vld_q[1]) begin
        dout_q <= dout_d;
      end
    end
  end

  assign DOUT = dout_q;
  assign VOUT = vout_q;

endmodule

// File: tb/tb_fir_param.sv
// Scoreboard bench for fir_param: one saturating and one wrapping instance share
// stimulus; a high-level arithmetic model predicts both outputs and their timing.
module tb_fir_param;

  localparam int N  = 8;
  localparam int DW = 13;
  localparam int CW = 13;

  logic                 CLK = 1'b0;
  logic                 RST_n;
  logic signed [DW-1:0] DIN;
  logic                 VIN;
  logic                 COEF_WE;
  logic [3:0]           COEF_ADDR;
  logic signed [CW-1:0] COEF_DATA;
  logic signed [DW-1:0] dout_s, dout_w;
  logic                 vout_s, vout_w;

  always #5 CLK = ~CLK;

  fir_param #(.N_TAPS(N), .DW(DW), .CW(CW), .SAT(1)) u_sat (
    .CLK(CLK), .RST_n(RST_n), .DIN(DIN), .VIN(VIN), .COEF_WE(COEF_WE),
    .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA), .DOUT(dout_s), .VOUT(vout_s));

  fir_param #(.N_TAPS(N), .DW(DW), .CW(CW), .SAT(0)) u_wrap (
    .CLK(CLK), .RST_n(RST_n), .DIN(DIN), .VIN(VIN), .COEF_WE(COEF_WE),
    .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA), .DOUT(dout_w), .VOUT(vout_w));

  typedef struct {
    longint s;
    longint w;
    longint due;
  } exp_t;

  exp_t   sbq[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint xm[N];
  longint hm[N];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      xm[i] = 0;
      hm[i] = 0;
    end
  endfunction

  // FIR as plain arithmetic: dot product, floor division by 2^(CW-1), then map.
  function automatic void model_sample(input longint din, input longint due);
    longint sum, r, m;
    exp_t e;
    for (int i = N - 1; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = din;
    sum = 0;
    for (int i = 0; i < N; i++) sum += xm[i] * hm[i];
    r = sum >>> (CW - 1);
    e.s = (r > 4095) ? 4095 : (r < -4096) ? -4096 : r;
    m = r & ((longint'(1) << DW) - 1);
    if (m >= (longint'(1) << (DW - 1))) m -= (longint'(1) << DW);
    e.w = m;
    e.due = due;
    sbq.push_back(e);
  endfunction

  task automatic step(input bit vin, input int din, input bit we, input int addr, input int data);
    @(negedge CLK);
    VIN       = vin;
    DIN       = DW'(din);
    COEF_WE   = we;
    COEF_ADDR = 4'(addr);
    COEF_DATA = CW'(data);
    @(posedge CLK);
    if (RST_n) begin
      if (we && addr < N) hm[addr] = data;
      if (vin) model_sample(din, $time + 20);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic impulse(input int amp);
    step(1, amp, 0, 0, 0);
    for (int i = 0; i < N - 1; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge CLK);
    chk("drain_pending", sbq.size(), 0);
  endtask

  // Monitor: pop on every strobe, otherwise require DOUT to hold.
  longint prev_s = 0, prev_w = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST_n) begin
        prev_s = 0;
        prev_w = 0;
      end else begin
        chk("vout_pair", vout_w, vout_s);
        if (vout_s) begin
          if (sbq.size() == 0) begin
            chk("unexpected_vout", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("dout_sat", dout_s, e.s);
            chk("dout_wrap", dout_w, e.w);
            chk("latency", $time - 5, e.due);
          end
        end else begin
          chk("hold_sat", dout_s, prev_s);
          chk("hold_wrap", dout_w, prev_w);
        end
        prev_s = dout_s;
        prev_w = dout_w;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    static bit gap_pat[12] = '{1, 0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1};
    int nv;
    RST_n = 1'b0; VIN = 0; DIN = '0; COEF_WE = 0; COEF_ADDR = '0; COEF_DATA = '0;
    model_clear();
    #12;
    chk("reset_dout", dout_s, 0);
    chk("reset_vout", vout_s, 0);
    @(negedge CLK);
    RST_n = 1'b1;

    // Impulse: h[i]=100*(i+1), expected 50..400
    for (int i = 0; i < N; i++) step(0, 0, 1, i, 100 * (i + 1));
    impulse(2048);
    idle(3);
    drain();

    // Out-of-range writes leave the taps alone
    step(0, 0, 1, 9, 1000);
    step(0, 0, 1, 8, 1000);
    step(0, 0, 1, 15, -1000);
    impulse(2048);
    idle(3);
    drain();

    // Gaps and back-to-back
    nv = 0;
    for (int i = 0; i < 12 && nv < N; i++) begin
      step(gap_pat[i], (nv == 0 && gap_pat[i]) ? 2048 : 0, 0, 0, 0);
      if (gap_pat[i]) nv++;
    end
    idle(3);
    drain();

    // Coefficient write on the same edge as the impulse VIN -> 2000 first
    step(1, 2048, 1, 0, 4000);
    for (int i = 0; i < N - 1; i++) step(1, 0, 0, 0, 0);
    idle(3);
    drain();

    // Saturation / wrap: all h=4095, DIN=4095 -> 4095 and -16
    for (int i = 0; i < N; i++) step(0, 0, 1, i, 4095);
    for (int i = 0; i < N + 3; i++) step(1, 4095, 0, 0, 0);
    idle(3);
    drain();

    // Most-negative by most-negative on a single tap
    for (int i = 1; i < N; i++) step(0, 0, 1, i, 0);
    step(0, 0, 1, 0, -4096);
    for (int i = 0; i < 3; i++) step(1, -4096, 0, 0, 0);
    idle(3);
    drain();

    // Randomized traffic with interleaved coefficient writes
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 8191)) - 4096,
           $urandom_range(0, 5) == 0, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 8191)) - 4096);
    end
    idle(3);
    drain();

    // Reset mid-stream with outputs in flight
    for (int i = 0; i < N; i++) step(0, 0, 1, i, 2000 + i);
    step(1, 3000, 0, 0, 0);
    step(1, -2500, 0, 0, 0);
    @(negedge CLK);
    VIN = 0;
    #2 RST_n = 1'b0;
    #1;
    chk("rst_mid_dout_sat", dout_s, 0);
    chk("rst_mid_dout_wrap", dout_w, 0);
    chk("rst_mid_vout", vout_s, 0);
    sbq.delete();
    model_clear();
    @(negedge CLK);
    #2 RST_n = 1'b1;
    idle(6);
    chk("rst_no_stray", sbq.size(), 0);
    impulse(2048);
    idle(3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
